// File: rtl/unsigned8b_seq_divider.sv
// unsigned8b_seq_divider
// Iterative unsigned restoring divider: recovers x = z / y from a 2W-bit product z
// and a W-bit factor y, one radix-2 iteration per clock, valid/ready on both sides.
// Optional feature macro: DIV_REM_OUT_EN adds the W-bit remainder output port rem.
module unsigned8b_seq_divider #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*W-1:0] z,
  input  logic [W-1:0]   y,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   x,
  output logic           div0,
  output logic           ovf
`ifdef DIV_REM_OUT_EN
  ,
  output logic [W-1:0]   rem
`endif
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  logic [W-1:0]   part_rem;
  logic [W-1:0]   q_shift;
  logic [W-1:0]   y_reg;
  logic [CW-1:0]  cnt;

`ifdef DIV_REM_OUT_EN
  logic [W-1:0]   rem_result;
  assign rem = rem_result;
`endif

  // One extra bit above the W+1-bit trial keeps the borrow visible as a sign bit.
  logic [W+1:0]   diff;
  logic           trial_neg;
  logic [W-1:0]   next_rem;
  logic [W-1:0]   next_q;

  // Accepting new work only from IDLE, and never while reset is held.
  assign in_ready = (state == IDLE) && !rst;

  // One restoring step: subtract y from the shifted partial remainder, keep it if non-negative.
  always_comb begin
    diff      = {1'b0, part_rem, q_shift[W-1]} - {2'b00, y_reg};
    trial_neg = diff[W+1];
    if (trial_neg) begin
      next_rem = {part_rem[W-2:0], q_shift[W-1]};
    end else begin
      next_rem = diff[W-1:0];
    end
    next_q = {q_shift[W-2:0], ~trial_neg};
  end

  // Control FSM plus datapath registers; all outputs are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      part_rem   <= '0;
      q_shift    <= '0;
      y_reg      <= '0;
      cnt        <= '0;
      out_valid  <= 1'b0;
      x          <= '0;
      div0       <= 1'b0;
      ovf        <= 1'b0;
`ifdef DIV_REM_OUT_EN
      rem_result <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            y_reg <= y;
            if (y == '0) begin
              div0       <= 1'b1;
              ovf        <= 1'b0;
              x          <= '1;
              part_rem   <= '0;
              out_valid  <= 1'b1;
              state      <= DONE;
`ifdef DIV_REM_OUT_EN
              rem_result <= '0;
`endif
            end else if (z[2*W-1:W] >= y) begin
              div0       <= 1'b0;
              ovf        <= 1'b1;
              x          <= '1;
              part_rem   <= '0;
              out_valid  <= 1'b1;
              state      <= DONE;
`ifdef DIV_REM_OUT_EN
              rem_result <= '0;
`endif
            end else begin
              div0     <= 1'b0;
              ovf      <= 1'b0;
              part_rem <= z[2*W-1:W];
              q_shift  <= z[W-1:0];
              cnt      <= CW'(W);
              state    <= BUSY;
            end
          end
        end
        BUSY: begin
          part_rem <= next_rem;
          q_shift  <= next_q;
          cnt      <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            x          <= next_q;
            out_valid  <= 1'b1;
            state      <= DONE;
`ifdef DIV_REM_OUT_EN
            rem_result <= next_rem;
`endif
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_unsigned8b_seq_divider.sv
// tb_unsigned8b_seq_divider
// Directed bench for unsigned8b_seq_divider with hand-computed expected results.
// Remainder checks are active only when DIV_REM_OUT_EN is defined.
module tb_unsigned8b_seq_divider;

  localparam int W = 8;

  logic           clk;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [2*W-1:0] z;
  logic [W-1:0]   y;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   x;
  logic           div0;
  logic           ovf;
`ifdef DIV_REM_OUT_EN
  logic [W-1:0]   rem;
`endif

  int checks = 0;
  int passes = 0;

  unsigned8b_seq_divider #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .z         (z),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .x         (x),
    .div0      (div0),
    .ovf       (ovf)
`ifdef DIV_REM_OUT_EN
    ,
    .rem       (rem)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one operand pair for exactly one accept edge.
  task automatic start_op(input logic [2*W-1:0] zv, input logic [W-1:0] yv);
    z        = zv;
    y        = yv;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    z         = '0;
    y         = '0;
    step();
    step();
    checks++;
    if (in_ready !== 1'b0) $display("[TB] FAIL reset_in_ready got=%b want=0", in_ready);
    else passes++;
    checks++;
    if ({out_valid, x, div0, ovf} !== '0)
      $display("[TB] FAIL reset_outputs got=%b/%h/%b/%b want=0/00/0/0", out_valid, x, div0, ovf);
    else passes++;
`ifdef DIV_REM_OUT_EN
    checks++;
    if (rem !== '0) $display("[TB] FAIL reset_rem got=%h want=00", rem);
    else passes++;
`endif
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) $display("[TB] FAIL post_reset_in_ready got=%b want=1", in_ready);
    else passes++;
  endtask

  task automatic test_normal(input string name, input logic [2*W-1:0] zv, input logic [W-1:0] yv,
                             input logic [W-1:0] ex, input logic [W-1:0] er);
    logic early;
    early = 1'b0;
    start_op(zv, yv);
    for (int i = 1; i < W; i++) begin
      step();
      if (out_valid !== 1'b0) early = 1'b1;
    end
    checks++;
    if (early) $display("[TB] FAIL %s_latency_early got=out_valid high before t+%0d want=low", name, W);
    else passes++;
    step();
    checks++;
    if (out_valid !== 1'b1) $display("[TB] FAIL %s_valid got=%b want=1", name, out_valid);
    else passes++;
    checks++;
    if ({x, div0, ovf} !== {ex, 1'b0, 1'b0})
      $display("[TB] FAIL %s_result got=x%0d/div0 %b/ovf %b want=x%0d/0/0", name, x, div0, ovf, ex);
    else passes++;
`ifdef DIV_REM_OUT_EN
    checks++;
    if (rem !== er) $display("[TB] FAIL %s_rem got=%0d want=%0d", name, rem, er);
    else passes++;
`else
    if (er > ex) $display("[TB] note %s remainder not observable in this build", name);
`endif
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++;
    if ({out_valid, in_ready} !== 2'b01)
      $display("[TB] FAIL %s_release got=valid %b ready %b want=0/1", name, out_valid, in_ready);
    else passes++;
  endtask

  task automatic test_error(input string name, input logic [2*W-1:0] zv, input logic [W-1:0] yv,
                            input logic ediv0, input logic eovf);
    start_op(zv, yv);
    checks++;
    if ({out_valid, x, div0, ovf} !== {1'b1, 8'hFF, ediv0, eovf})
      $display("[TB] FAIL %s got=valid %b x %h div0 %b ovf %b want=1/ff/%b/%b",
               name, out_valid, x, div0, ovf, ediv0, eovf);
    else passes++;
`ifdef DIV_REM_OUT_EN
    checks++;
    if (rem !== '0) $display("[TB] FAIL %s_rem got=%0d want=0", name, rem);
    else passes++;
`endif
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++;
    if ({out_valid, in_ready} !== 2'b01)
      $display("[TB] FAIL %s_release got=valid %b ready %b want=0/1", name, out_valid, in_ready);
    else passes++;
  endtask

  task automatic test_backpressure();
    logic bad;
    bad      = 1'b0;
    z        = 16'd100;
    y        = 8'd7;
    in_valid = 1'b1;
    step();
    for (int i = 1; i <= W; i++) step();
    checks++;
    if ({out_valid, x} !== {1'b1, 8'd14})
      $display("[TB] FAIL bp_result got=valid %b x %0d want=1/14", out_valid, x);
    else passes++;
    for (int i = 0; i < 5; i++) begin
      step();
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || x !== 8'd14) bad = 1'b1;
`ifdef DIV_REM_OUT_EN
      if (rem !== 8'd2) bad = 1'b1;
`endif
    end
    checks++;
    if (bad) $display("[TB] FAIL bp_hold got=valid %b ready %b x %0d want=1/0/14 held", out_valid, in_ready, x);
    else passes++;
    out_ready = 1'b1;
    step();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checks++;
    if ({out_valid, in_ready} !== 2'b01)
      $display("[TB] FAIL bp_release got=valid %b ready %b want=0/1", out_valid, in_ready);
    else passes++;
  endtask

  task automatic test_mid_reset();
    logic pulsed;
    pulsed = 1'b0;
    start_op(16'd100, 8'd7);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid} !== 2'b10)
      $display("[TB] FAIL midrst_state got=ready %b valid %b want=1/0", in_ready, out_valid);
    else passes++;
    for (int i = 0; i < W + 2; i++) begin
      step();
      if (out_valid !== 1'b0) pulsed = 1'b1;
    end
    checks++;
    if (pulsed) $display("[TB] FAIL midrst_no_pulse got=out_valid pulsed want=never");
    else passes++;
    test_normal("after_rst", 16'd81, 8'd9, 8'd9, 8'd0);
  endtask

  initial begin
    test_reset();
    test_normal("t1_6000_25", 16'd6000, 8'd25, 8'd240, 8'd0);
    test_normal("t2_65024_255", 16'd65024, 8'd255, 8'd254, 8'd254);
    test_normal("boundary_255_1", 16'd255, 8'd1, 8'd255, 8'd0);
    test_error("t3_div0", 16'd1234, 8'd0, 1'b1, 1'b0);
    test_error("t4_ovf", 16'h1900, 8'd25, 1'b0, 1'b1);
    test_backpressure();
    test_mid_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
